// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
// Holds the FSM state encoding, funct3 width codes and exception cause codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISAL  = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT  = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISAL  = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT  = 4'd7;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
// Purely combinational; assumes the access has already passed the alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  assign shifted = load_word >> {addr_lo, 3'b000};

  always_comb begin
    wdata = store_data;
    be    = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        wdata = {4{store_data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      2'b01: begin
        wdata = {2{store_data[15:0]}};
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = store_data;
        be    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    load_data = shifted;
    case (funct3)
      F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  load_data = {24'd0, shifted[7:0]};
      F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// RV32I load/store stage: accepts one op from execute, runs one data-memory access
// with timeout, and hands a one-cycle completion/exception pulse to writeback.
//   state  | meaning
//   IDLE   | ready for a new op from execute
//   BUS    | request held on the data-memory bus, waiting for ack or timeout
//   DONE   | one-cycle writeback / exception pulse
module lsu_stage
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 16,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [3:0]  exc_cause,
  output logic [31:0] exc_addr
);

  localparam logic [31:0] CNT_INIT = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  lsu_state_t  state, state_n;
  logic        load_q, store_q, exc_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q, rdata_q, cnt_q;
  logic [4:0]  rd_q;
  logic [3:0]  cause_q;

  logic        accept, illegal, misaligned, timeout_hit;
  logic [31:0] al_wdata, al_load;
  logic [3:0]  al_be;

  assign accept = (state == S_IDLE) && ex_valid && (ex_load || ex_store);

  assign illegal = (ex_load && ex_store)
                || (ex_load && (ex_funct3 == 3'b011 || ex_funct3 == 3'b110 || ex_funct3 == 3'b111))
                || (ex_store && ex_funct3[2]);

  assign misaligned = (ex_funct3[1:0] == 2'b01 && ex_addr[0])
                   || (ex_funct3[1:0] == 2'b10 && ex_addr[1:0] != 2'b00);

  // Down-counter reaching zero without an ack is the timeout; an ack that same cycle wins.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == 32'd0) && !dmem_ack;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = (illegal || misaligned) ? S_DONE : S_BUS;
      S_BUS:   if (dmem_ack || timeout_hit) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= RESET_ADDR;
      wdata_q  <= 32'd0;
      rd_q     <= 5'd0;
      rdata_q  <= 32'd0;
      cnt_q    <= 32'd0;
      exc_q    <= 1'b0;
      cause_q  <= 4'd0;
    end else begin
      state <= state_n;
      if (accept) begin
        load_q   <= ex_load;
        store_q  <= ex_store;
        funct3_q <= ex_funct3;
        addr_q   <= ex_addr;
        wdata_q  <= ex_wdata;
        rd_q     <= ex_rd;
        cnt_q    <= CNT_INIT;
        exc_q    <= illegal || misaligned;
        cause_q  <= illegal ? CAUSE_ILLEGAL : (ex_load ? CAUSE_LD_MISAL : CAUSE_ST_MISAL);
      end else if (state == S_BUS) begin
        if (dmem_ack) begin
          rdata_q <= dmem_rdata;
        end else if (timeout_hit) begin
          exc_q   <= 1'b1;
          cause_q <= load_q ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
        end else if (cnt_q != 32'd0) begin
          cnt_q <= cnt_q - 32'd1;
        end
      end
    end
  end

  lsu_align u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .store_data (wdata_q),
    .load_word  (rdata_q),
    .wdata      (al_wdata),
    .be         (al_be),
    .load_data  (al_load)
  );

  // Bus outputs derive from state so a reset drops the request without waiting for a clock.
  assign ex_ready   = (state == S_IDLE);
  assign dmem_req   = (state == S_BUS);
  assign dmem_we    = dmem_req && store_q;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_wdata = dmem_req ? al_wdata : 32'd0;
  assign dmem_be    = dmem_req ? al_be : 4'd0;

  assign wb_valid  = (state == S_DONE);
  assign exc_valid = wb_valid && exc_q;
  assign wb_we     = wb_valid && load_q && !exc_q && (rd_q != 5'd0);
  assign wb_rd     = rd_q;
  assign wb_data   = wb_we ? al_load : 32'd0;
  assign exc_cause = exc_valid ? cause_q : 4'd0;
  assign exc_addr  = addr_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed scoreboard bench for lsu_stage: stimulus pushes expected writeback
// pulses, a negedge monitor pops and compares whenever wb_valid is seen.
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0, ex_load = 1'b0, ex_store = 1'b0;
  logic [2:0]  ex_funct3 = 3'd0;
  logic [31:0] ex_addr = 32'd0, ex_wdata = 32'd0;
  logic [4:0]  ex_rd = 5'd0;
  logic        ex_ready;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 32'd0;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_we, exc_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_addr;
  logic [3:0]  exc_cause;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    logic [3:0]  cause;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_stage #(.TIMEOUT(16), .RESET_ADDR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic [4:0] rd, input logic [31:0] data,
                              input logic exc, input logic [3:0] cause, input logic [31:0] addr);
    exp_t e;
    e.we = we; e.rd = rd; e.data = data; e.exc = exc; e.cause = cause; e.addr = addr;
    return e;
  endfunction

  // Monitor: every wb_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && wb_valid) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_data", wb_data, e.data);
        chk("exc_valid", {31'd0, exc_valid}, {31'd0, e.exc});
        chk("exc_cause", {28'd0, exc_cause}, {28'd0, e.cause});
        if (e.exc) chk("exc_addr", exc_addr, e.addr);
      end
    end
  end

  // Present one op and return #1 after the accepting edge.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    int g;
    @(negedge clk);
    g = 0;
    while (!ex_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!ex_ready) chk("ex_ready_wait", 32'd0, 32'd1);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
    ex_addr = a; ex_wdata = wd; ex_rd = rd;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  // Called #1 into the first BUS cycle: wait n cycles, ack, then check the pulse timing.
  task automatic ack_after(input int n, input logic [31:0] rdata);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    chk("req_held_until_ack", {31'd0, dmem_req}, 32'd1);
    chk("no_wb_before_ack", {31'd0, wb_valid}, 32'd0);
    dmem_ack = 1'b1;
    dmem_rdata = rdata;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    chk("wb_after_ack", {31'd0, wb_valid}, 32'd1);
    chk("req_drop_after_ack", {31'd0, dmem_req}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    chk("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_wb", {wb_valid, wb_we, exc_valid, 24'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_exc", {28'd0, exc_cause} | exc_addr, 32'd0);
    @(negedge clk) reset = 1'b0;

    // SW 0xDEADBEEF at 0x100, three wait cycles.
    exp_q.push_back(mk(1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 32'h100));
    issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd0);
    chk("sw_ex_ready_low", {31'd0, ex_ready}, 32'd0);
    chk("sw_req", {31'd0, dmem_req}, 32'd1);
    chk("sw_we", {31'd0, dmem_we}, 32'd1);
    chk("sw_addr", dmem_addr, 32'h100);
    chk("sw_be", {28'd0, dmem_be}, 32'hF);
    chk("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
    ack_after(3, 32'h0);

    // LB / LBU at 0x103 from a word whose top byte is 0x80.
    exp_q.push_back(mk(1'b1, 5'd5, 32'hFFFF_FF80, 1'b0, 4'd0, 32'h103));
    issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd5);
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_we", {31'd0, dmem_we}, 32'd0);
    ack_after(0, 32'h80FF_FFFF);
    exp_q.push_back(mk(1'b1, 5'd6, 32'h0000_0080, 1'b0, 4'd0, 32'h103));
    issue(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd6);
    ack_after(1, 32'h80FF_FFFF);

    // SH 0x1234 at 0x102.
    exp_q.push_back(mk(1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 32'h102));
    issue(1'b0, 1'b1, 3'b001, 32'h102, 32'hAAAA_1234, 5'd0);
    chk("sh_wdata", dmem_wdata, 32'h1234_1234);
    chk("sh_be", {28'd0, dmem_be}, 32'hC);
    ack_after(0, 32'h0);

    // LHU at 0x102 picks the upper half without extension.
    exp_q.push_back(mk(1'b1, 5'd9, 32'h0000_8765, 1'b0, 4'd0, 32'h102));
    issue(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 5'd9);
    ack_after(2, 32'h8765_4321);

    // LH at 0x101: misaligned, never reaches the bus.
    exp_q.push_back(mk(1'b0, 5'd4, 32'd0, 1'b1, 4'd4, 32'h101));
    issue(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 5'd4);
    chk("lh_mis_no_req", {31'd0, dmem_req}, 32'd0);
    chk("lh_mis_wb_now", {31'd0, wb_valid}, 32'd1);

    // SW at 0x106: store misaligned.
    exp_q.push_back(mk(1'b0, 5'd0, 32'd0, 1'b1, 4'd6, 32'h106));
    issue(1'b0, 1'b1, 3'b010, 32'h106, 32'h1, 5'd0);
    chk("sw_mis_no_req", {31'd0, dmem_req}, 32'd0);

    // Load funct3=011 and load+store both: illegal.
    exp_q.push_back(mk(1'b0, 5'd2, 32'd0, 1'b1, 4'd2, 32'h40));
    issue(1'b1, 1'b0, 3'b011, 32'h40, 32'h0, 5'd2);
    exp_q.push_back(mk(1'b0, 5'd2, 32'd0, 1'b1, 4'd2, 32'h44));
    issue(1'b1, 1'b1, 3'b010, 32'h44, 32'h0, 5'd2);
    chk("illegal_no_req", {31'd0, dmem_req}, 32'd0);

    // Neither load nor store: ignored.
    @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    chk("nop_stays_idle", {31'd0, ex_ready}, 32'd1);

    // LW with no ack: 16 request cycles then a load fault; a late ack is ignored.
    exp_q.push_back(mk(1'b0, 5'd7, 32'd0, 1'b1, 4'd5, 32'h200));
    issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd7);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!dmem_req) break;
      n++;
      @(posedge clk);
      #1;
    end
    chk("timeout_req_cycles", n, 32'd16);
    @(posedge clk);
    #1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h5555_5555;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    chk("late_ack_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("late_ack_idle", {31'd0, ex_ready}, 32'd1);

    // Reset in the middle of BUS.
    issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rst_mid_bus_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_mid_bus_wb", {31'd0, wb_valid}, 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_release_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_release_wb", {31'd0, wb_valid}, 32'd0);

    // LW rd=0 with immediate ack, next op held valid and accepted 3 cycles later.
    exp_q.push_back(mk(1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 32'h300));
    exp_q.push_back(mk(1'b1, 5'd3, 32'hCAFE_F00D, 1'b0, 4'd0, 32'h304));
    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd0);
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b010;
    ex_addr = 32'h304; ex_rd = 5'd3;
    chk("b2b_ready_bus", {31'd0, ex_ready}, 32'd0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1122_3344;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    chk("b2b_ready_done", {31'd0, ex_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("b2b_ready_idle", {31'd0, ex_ready}, 32'd1);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    chk("b2b_second_req", {31'd0, dmem_req}, 32'd1);
    chk("b2b_second_addr", dmem_addr, 32'h304);
    ack_after(0, 32'hCAFE_F00D);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
